prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- UART-driven program loader upstream of the fetch stage.
- Assembles a framed byte stream into 32-bit words and writes them into instruction memory through its write port. Word address matches the fetch address PC[15:2].
- Holds the CPU via cpu_hold while loading, and releases it only after a good checksum.
- Sits between the UART byte receiver and the instruction ROM/RAM write port.

Parameters:
ADDR_W, 14, word-address width of instruction memory
MAX_WORDS, 16384, largest accepted word count
TIMEOUT_CYC, 1000000, idle clocks allowed between bytes mid-frame before abort
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
rx_data  input  8  received byte, valid only when rx_valid=1
rx_valid  input  1  one-cycle strobe per received byte
start_load  input  1  level from debounced button; rising edge arms a load
imem_we  output  1  one-cycle write strobe to instruction memory
imem_addr  output  ADDR_W  word address for the write
imem_wdata  output  32  word to write
cpu_hold  output  1  1 = CPU held in reset, PC must stay at 0
done  output  1  load completed with a good checksum
err  output  1  load aborted (bad count, checksum, or timeout)

Behaviour:
- Reset (reset=0, async): state=IDLE; every output 0; counters, checksum and word buffer cleared.
- Frame format:
  - SYNC_BYTE.
  - Count high byte, then count low byte (N, 16-bit).
  - N words, 4 bytes each, little-endian: first byte -> wdata[7:0].
  - One checksum byte: XOR of the 4N data bytes only (0x00 when N=0).
- start_load edge detection: registered previous value. An edge is start_load=1 while prev=0.
- States:
  - IDLE: cpu_hold=0. Edge -> SYNC.
  - SYNC: cpu_hold=1, done=0, err=0. rx_valid with SYNC_BYTE -> CNT_HI. Any other byte is ignored and the state stays SYNC. The timeout is not active here.
  - CNT_HI: byte -> count[15:8], then CNT_LO.
  - CNT_LO: byte -> count[7:0]. If count > MAX_WORDS -> ERROR. If count = 0 -> CSUM. Otherwise -> DATA, with word index=0, byte index=0, checksum=0.
  - DATA: each byte is shifted into wdata lane byte_idx and XORed into the checksum. On the 4th byte, imem_we=1 on the next cycle, for exactly one cycle, with imem_addr=word index and the complete word. The word index then increments. After word N-1 is written -> CSUM.
  - CSUM: received byte equals the checksum -> DONE; otherwise -> ERROR.
  - DONE: done=1, cpu_hold=0. Edge -> SYNC.
  - ERROR: err=1, cpu_hold=1 (the CPU never runs a partial image). Edge -> SYNC.
- Timeout: a counter runs in CNT_HI, CNT_LO, DATA and CSUM. It clears on every rx_valid. It reaching TIMEOUT_CYC-1 -> ERROR.
- Interactions and ignored inputs:
  - A start_load edge in any non-IDLE state restarts at SYNC and clears the partial word, index and checksum.
  - A start_load edge in the same cycle as rx_valid: the restart wins and the byte is dropped.
  - rx_valid in IDLE, DONE or ERROR is ignored.
- Addressing and hold timing:
  - imem_addr never wraps; MAX_WORDS guarantees indices stay below 2^ADDR_W.
  - imem_addr and imem_wdata are held stable while imem_we=0. Their values are don't-care outside write cycles.
  - cpu_hold changes only on the clock edge that enters or leaves the states above, so the CPU leaves hold with the image fully written.
- Reset asserted mid-frame: the immediate return to IDLE and the cleared outputs apply. Memory already written is left as is.

Test Plan:
- Load with N=2:
  - Stimulus: start_load edge, then bytes A5 00 02 05 00 08 20 00 00 00 00 2D.
  - Required: imem_we pulses twice, at (addr 0, 32'h20080005) and (addr 1, 32'h00000000).
  - Then done=1, cpu_hold=0, err=0.
- Bad checksum: same frame with last byte 2C -> both writes occur, err=1, cpu_hold stays 1, done=0.
- Zero count and noise:
  - Stimulus: 3C then A5 00 00 00.
  - Required: 3C ignored in SYNC, no imem_we, done=1.
- Oversize count: A5 40 01 -> ERROR right after CNT_LO, no writes.
- Timeout:
  - Setup: TIMEOUT_CYC=100, frame stopped after 2 data bytes.
  - Required: err=1 exactly 100 cycles after the last rx_valid, no imem_we.
- Restart and reset:
  - Restart: start_load edge after 6 bytes, then a full good frame -> writes start at addr 0 with correct data.
  - Reset: reset=0 mid-DATA -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/prog_loader_if.sv
// ---------------------------------------------------------------------------
// prog_loader_if
// Groups the byte-receiver input, the load button and the instruction-memory
// write port of the program loader into one bundle.
//   rx_data    [7:0]        received UART byte, qualified by rx_valid
//   rx_valid                one-cycle strobe per received byte
//   start_load              debounced button level; rising edge arms a load
//   imem_we                 one-cycle instruction-memory write strobe
//   imem_addr  [ADDR_W-1:0] word address of the write (matches PC[15:2])
//   imem_wdata [31:0]       word to write
//   cpu_hold                1 = CPU held in reset
//   done                    load finished with a good checksum
//   err                     load aborted
// The slave modport is the loader; the master modport is its environment.
// ---------------------------------------------------------------------------
interface prog_loader_if #(
    parameter int ADDR_W = 14
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              start_load;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    modport slave (
        input  rx_data, rx_valid, start_load,
        output imem_we, imem_addr, imem_wdata, cpu_hold, done, err
    );

    modport master (
        output rx_data, rx_valid, start_load,
        input  imem_we, imem_addr, imem_wdata, cpu_hold, done, err
    );
endinterface

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
// UART-driven program loader in front of the fetch stage. Parses the frame
//   SYNC_BYTE, count_hi, count_lo, N x 4 data bytes (little-endian), xor-sum
// writes each assembled word into instruction memory and keeps the CPU in
// hold until a complete image with a matching checksum has been written.
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    prog_loader_if.slave (byte input, button, imem write, status)
// ---------------------------------------------------------------------------
module prog_loader #(
    parameter int          ADDR_W      = 14,
    parameter int unsigned MAX_WORDS   = 16384,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic         clock,
    input  logic         reset,
    prog_loader_if.slave bus
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE, SYNC, CNT_HI, CNT_LO, DATA, CSUM, DONE, ERROR
    } state_t;

    state_t            r_state;
    logic              r_start_prev;
    logic [15:0]       r_count;
    logic [15:0]       r_left;      // words still to be written
    logic [ADDR_W-1:0] r_widx;
    logic [1:0]        r_bidx;
    logic [23:0]       r_wbuf;      // first three bytes of the current word
    logic [7:0]        r_csum;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_hold;
    logic              r_done;
    logic              r_err;

    logic              w_edge;
    logic              w_tmo_active;
    logic              w_tmo_hit;
    logic [15:0]       w_count;

    assign w_edge       = bus.start_load & ~r_start_prev;
    assign w_tmo_active = (r_state == CNT_HI) || (r_state == CNT_LO) ||
                          (r_state == DATA)   || (r_state == CSUM);
    // A byte arriving on the limit cycle still counts as in time.
    assign w_tmo_hit    = w_tmo_active && !bus.rx_valid &&
                          (r_tmo == TMO_W'(TIMEOUT_CYC - 1));
    assign w_count      = {r_count[15:8], bus.rx_data};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_start_prev <= 1'b0;
            r_count      <= '0;
            r_left       <= '0;
            r_widx       <= '0;
            r_bidx       <= '0;
            r_wbuf       <= '0;
            r_csum       <= '0;
            r_tmo        <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_hold       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_start_prev <= bus.start_load;
            r_we         <= 1'b0;

            if (w_edge) begin
                // Restart from any state; a byte in the same cycle is dropped.
                r_state <= SYNC;
                r_hold  <= 1'b1;
                r_done  <= 1'b0;
                r_err   <= 1'b0;
                r_count <= '0;
                r_left  <= '0;
                r_widx  <= '0;
                r_bidx  <= '0;
                r_wbuf  <= '0;
                r_csum  <= '0;
                r_tmo   <= '0;
            end else if (w_tmo_hit) begin
                r_state <= ERROR;
                r_err   <= 1'b1;
                r_tmo   <= '0;
            end else begin
                if (w_tmo_active && !bus.rx_valid)
                    r_tmo <= r_tmo + TMO_W'(1);
                else
                    r_tmo <= '0;

                case (r_state)
                    SYNC: begin
                        if (bus.rx_valid && bus.rx_data == SYNC_BYTE)
                            r_state <= CNT_HI;
                    end
                    CNT_HI: begin
                        if (bus.rx_valid) begin
                            r_count[15:8] <= bus.rx_data;
                            r_state       <= CNT_LO;
                        end
                    end
                    CNT_LO: begin
                        if (bus.rx_valid) begin
                            r_count[7:0] <= bus.rx_data;
                            r_csum       <= '0;
                            if ({16'd0, w_count} > MAX_WORDS) begin
                                r_state <= ERROR;
                                r_err   <= 1'b1;
                            end else if (w_count == 16'd0) begin
                                r_state <= CSUM;
                            end else begin
                                r_state <= DATA;
                                r_left  <= w_count;
                                r_widx  <= '0;
                                r_bidx  <= '0;
                            end
                        end
                    end
                    DATA: begin
                        if (bus.rx_valid) begin
                            r_csum <= r_csum ^ bus.rx_data;
                            r_bidx <= r_bidx + 2'd1;
                            case (r_bidx)
                                2'd0: r_wbuf[7:0]   <= bus.rx_data;
                                2'd1: r_wbuf[15:8]  <= bus.rx_data;
                                2'd2: r_wbuf[23:16] <= bus.rx_data;
                                default: begin
                                    // Fourth byte completes the word; the
                                    // strobe appears on the following cycle.
                                    r_we    <= 1'b1;
                                    r_addr  <= r_widx;
                                    r_wdata <= {bus.rx_data, r_wbuf};
                                    r_widx  <= r_widx + ADDR_W'(1);
                                    r_left  <= r_left - 16'd1;
                                    if (r_left == 16'd1)
                                        r_state <= CSUM;
                                end
                            endcase
                        end
                    end
                    CSUM: begin
                        if (bus.rx_valid) begin
                            if (bus.rx_data == r_csum) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                                r_hold  <= 1'b0;
                            end else begin
                                r_state <= ERROR;
                                r_err   <= 1'b1;
                            end
                        end
                    end
                    default: ;  // IDLE, DONE, ERROR wait for a button edge
                endcase
            end
        end
    end

    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign bus.cpu_hold   = r_hold;
    assign bus.done       = r_done;
    assign bus.err        = r_err;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    localparam int ADDR_W = 14;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    wr_t  exp_q[$];

    prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

    prog_loader #(
        .ADDR_W(ADDR_W), .MAX_WORDS(16384), .TIMEOUT_CYC(100), .SYNC_BYTE(8'hA5)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe is matched against the scoreboard.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.imem_addr), 32'(e.a));
                chk("wr_data", bus.imem_wdata, e.d);
            end
        end
    end

    // Called at a falling edge; returns at a falling edge.
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_seq(input bq_t s);
        foreach (s[i]) send_byte(s[i]);
    endtask

    task automatic pulse_start();
        bus.start_load = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.start_load = 1'b0;
        @(negedge clk);
    endtask

    task automatic push_good_words();
        exp_q.push_back('{a: 14'd0, d: 32'h20080005});
        exp_q.push_back('{a: 14'd1, d: 32'h00000000});
    endtask

    task automatic chk_status(input string tag, input logic d, input logic e, input logic h);
        chk({tag, "_done"}, 32'(bus.done), 32'(d));
        chk({tag, "_err"},  32'(bus.err),  32'(e));
        chk({tag, "_hold"}, 32'(bus.cpu_hold), 32'(h));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t good, bad, part;
        int  cyc;
        checks = 0;
        errors = 0;
        good = '{8'hA5, 8'h00, 8'h02, 8'h05, 8'h00, 8'h08, 8'h20,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h2D};
        bad  = '{8'hA5, 8'h00, 8'h02, 8'h05, 8'h00, 8'h08, 8'h20,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h2C};

        rst_n          = 1'b0;
        bus.rx_data    = 8'h00;
        bus.rx_valid   = 1'b0;
        bus.start_load = 1'b0;
        repeat (3) @(negedge clk);
        chk_status("reset", 1'b0, 1'b0, 1'b0);
        chk("reset_we", 32'(bus.imem_we), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Good load, N=2
        pulse_start();
        chk_status("sync", 1'b0, 1'b0, 1'b1);
        push_good_words();
        send_seq(good);
        repeat (2) @(negedge clk);
        chk_status("good", 1'b1, 1'b0, 1'b0);
        chk("good_writes", 32'(exp_q.size()), 32'd0);

        // Bad checksum: writes still happen
        pulse_start();
        chk_status("resync", 1'b0, 1'b0, 1'b1);
        push_good_words();
        send_seq(bad);
        repeat (2) @(negedge clk);
        chk_status("badcs", 1'b0, 1'b1, 1'b1);
        chk("badcs_writes", 32'(exp_q.size()), 32'd0);

        // Noise byte then zero-count frame
        pulse_start();
        send_byte(8'h3C);
        chk_status("noise", 1'b0, 1'b0, 1'b1);
        send_seq('{8'hA5, 8'h00, 8'h00, 8'h00});
        chk_status("zero", 1'b1, 1'b0, 1'b0);

        // Oversize count 0x4001
        pulse_start();
        send_seq('{8'hA5, 8'h40});
        chk("over_pre_err", 32'(bus.err), 32'd0);
        send_byte(8'h01);
        chk_status("over", 1'b0, 1'b1, 1'b1);

        // Timeout after two data bytes
        pulse_start();
        send_seq('{8'hA5, 8'h00, 8'h01, 8'h05});
        send_byte(8'h00);
        cyc = 1;
        while (bus.err !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk("timeout_cycles", 32'(cyc), 32'd100);
        chk_status("timeout", 1'b0, 1'b1, 1'b1);

        // Restart mid-frame, then a full good frame
        pulse_start();
        part = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
        send_seq(part);
        pulse_start();
        push_good_words();
        send_seq(good);
        repeat (2) @(negedge clk);
        chk_status("restart", 1'b1, 1'b0, 1'b0);
        chk("restart_writes", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of DATA
        pulse_start();
        send_seq('{8'hA5, 8'h00, 8'h02, 8'h05, 8'h00});
        chk("pre_reset_hold", 32'(bus.cpu_hold), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_status("async_rst", 1'b0, 1'b0, 1'b0);
        chk("async_rst_we", 32'(bus.imem_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // Bytes with no button edge are ignored in IDLE
        send_seq('{8'hA5, 8'h00, 8'h00, 8'h00});
        chk_status("idle", 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
